code_rx: RTL and testbench
==========================

# code_rx

Parametrised serial frame receiver for the microcontroller link. It hunts for a sync byte on the 1-bit `code` line and shifts in N_BYTES ASCII payload bytes, LSB first, one bit per `bit_en` strobe. It checks that every byte is a decimal digit and converts the frame to packed BCD. It sits between the MCU pin synchroniser and the game logic, and generalises the fixed 48-bit receiver: configurable length, sync detection, a validity strobe, error reporting and an inter-bit timeout.

## Interface
- N_BYTES, 4: payload bytes per frame, range 1..16.
- SYNC, 8'hA5: sync byte that precedes every frame.
- TIMEOUT, 1024: clk cycles allowed between `bit_en` strobes inside a frame, at least 2.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- bit_en  in  1  sample strobe; `code` is valid in a cycle where this is high.
- code  in  1  serial data from the MCU, already synchronised.
- code_out  out  4*N_BYTES  packed BCD of the last good frame. The first received byte goes in the most-significant nibble.
- code_valid  out  1  one-cycle pulse when `code_out` updates.
- frame_err  out  1  one-cycle pulse on a bad digit or a timeout.
- busy  out  1  high in RECV and CHECK.

## Operation
- Reset values:
  - state = HUNT.
  - `code_out` = 0.
  - `code_valid`, `frame_err` and `busy` = 0.
  - Window, shift register and counters = 0.
- HUNT:
  - On each `bit_en`, `win <= {code, win[7:1]}`.
  - If the updated value equals SYNC, go to RECV with bit count 0 and timer 0.
  - `bit_en` low: no change.
- RECV:
  - On each `bit_en`, shift `code` into the payload register at index `bitcnt` (LSB first within the current byte), increment `bitcnt`, and clear the timer.
  - When the accepted bit is bit 8*N_BYTES-1, go to CHECK.
  - With no `bit_en`, the timer increments. When it reaches TIMEOUT-1, pulse `frame_err`, go to HUNT and clear `win`.
- CHECK (always exactly one cycle):
  - Every byte must lie in 8'h30..8'h39. A valid byte maps to nibble = byte − 8'h30, using an 8-bit subtract and keeping the low 4 bits.
  - All bytes valid: register `code_out`, pulse `code_valid`, go to HUNT.
  - Any byte invalid: `code_out` holds its old value, pulse `frame_err`, go to HUNT.
  - `bit_en` in this cycle is ignored. The MCU guarantees an idle gap after each frame.
- The sync pattern is not searched for inside the payload. A payload byte equal to SYNC is simply treated as data.
- `win` is cleared on entry to HUNT. Sync therefore needs 8 fresh bits.
- `code_valid` and `frame_err` are never high together.
- Asserting `rst_n` mid-frame discards the partial frame immediately. `code_out` also returns to 0.

## Timing
- Last payload bit accepted at edge k. At edge k+1, `code_out`, `code_valid` or `frame_err` are registered and the state returns to HUNT. The pulse is high for the single cycle between edges k+1 and k+2.
- `busy` rises at the edge where sync is detected. It falls at edge k+1.
- Timeout: with the last strobe at edge t, `frame_err` is registered at edge t+TIMEOUT.
- Back-to-back: the next frame's sync bits may start at edge k+2.
- All outputs are registered. There is no combinational path from input to output.

## Structure
- Shared package `code_rx_pkg` holds:
  - the state enum (HUNT, RECV, CHECK);
  - ASCII_ZERO = 8'h30 and ASCII_NINE = 8'h39;
  - the default SYNC value.
- Sub-module `ascii_digit_dec`: 8-bit byte in; 4-bit nibble plus `is_digit` out; purely combinational. It is instantiated N_BYTES times via generate.
- Counter widths are derived with $clog2(8*N_BYTES) and $clog2(TIMEOUT).

## Test plan
- N_BYTES=4, serial A5 then "1234" (31 32 33 34), LSB first, `bit_en` every 4 clk. Expect `code_out` = 16'h1234, `code_valid` high for 1 cycle, `frame_err` never high.
- Frame A5 "12A4" (0x41 in byte 3). Expect `frame_err` pulse, `code_out` holds 16'h1234, `code_valid` stays 0.
- Noise 0x5A 0xFF, then A5 "9876". Expect HUNT to skip the noise and `code_out` = 16'h9876. Then repeat with the payload byte "A5" replaced by 35 and check it is treated as data.
- TIMEOUT=16: send sync plus 10 payload bits, then idle. Expect `frame_err` exactly 16 clk after the last strobe, then a following clean frame is accepted.
- `rst_n` low for 2 cycles after 20 payload bits. Expect all outputs at 0 and `busy` low. A fresh A5 "0000" then yields `code_valid` and `code_out` = 0.
- N_BYTES=1 with back-to-back frames A5 "7", then A5 "3" starting 2 cycles after the first `code_valid`. Expect two pulses with `code_out` = 4'h7, then 4'h3.

Source files
------------

// File: rtl/code_rx_pkg.sv
// Shared definitions for the serial code receiver: FSM states, ASCII digit
// bounds and the default frame sync byte.
package code_rx_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } rx_state_t;

  localparam logic [7:0] ASCII_ZERO   = 8'h30;
  localparam logic [7:0] ASCII_NINE   = 8'h39;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/ascii_digit_dec.sv
// Combinational ASCII decimal digit decoder: flags '0'..'9' and yields the
// BCD nibble (low four bits of the byte minus ASCII '0').
module ascii_digit_dec
  import code_rx_pkg::*;
(
  input  logic [7:0] ascii,
  output logic [3:0] nibble,
  output logic       is_digit
);

  assign nibble   = 4'(ascii - ASCII_ZERO);
  assign is_digit = (ascii >= ASCII_ZERO) && (ascii <= ASCII_NINE);

endmodule

// File: rtl/code_rx.sv
// Serial frame receiver: hunts for SYNC, shifts in N_BYTES ASCII digits LSB
// first on bit_en, and publishes them as packed BCD (first byte in top nibble).
module code_rx
  import code_rx_pkg::*;
#(
  parameter int         N_BYTES = 4,
  parameter logic [7:0] SYNC    = SYNC_DEFAULT,
  parameter int         TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   bit_en,
  input  logic                   code,
  output logic [4*N_BYTES-1:0]   code_out,
  output logic                   code_valid,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int NBITS = 8 * N_BYTES;
  localparam int CNT_W = $clog2(NBITS);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(NBITS - 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT - 1);

  rx_state_t            state, state_n;
  logic [7:0]           win, win_n;
  logic [NBITS-1:0]     payload, payload_n;
  logic [CNT_W-1:0]     bitcnt, bitcnt_n;
  logic [TMR_W-1:0]     timer, timer_n;
  logic [4*N_BYTES-1:0] code_out_n;
  logic                 code_valid_n, frame_err_n;

  logic [4*N_BYTES-1:0] bcd;
  logic [N_BYTES-1:0]   is_digit;

  // Byte 0 arrives first and lands in the most-significant nibble.
  for (genvar i = 0; i < N_BYTES; i++) begin : g_dec
    ascii_digit_dec u_dec (
      .ascii    (payload[8*i +: 8]),
      .nibble   (bcd[4*(N_BYTES-1-i) +: 4]),
      .is_digit (is_digit[i])
    );
  end

  always_comb begin
    state_n      = state;
    win_n        = win;
    payload_n    = payload;
    bitcnt_n     = bitcnt;
    timer_n      = timer;
    code_out_n   = code_out;
    code_valid_n = 1'b0;
    frame_err_n  = 1'b0;
    unique case (state)
      HUNT: begin
        if (bit_en) begin
          win_n = {code, win[7:1]};
          if (win_n == SYNC) begin
            state_n  = RECV;
            bitcnt_n = '0;
            timer_n  = '0;
          end
        end
      end
      RECV: begin
        if (bit_en) begin
          payload_n[bitcnt] = code;
          bitcnt_n          = bitcnt + CNT_W'(1);
          timer_n           = '0;
          if (bitcnt == LAST_BIT) state_n = CHECK;
        end else if (timer == TMR_LIMIT) begin
          frame_err_n = 1'b1;
          state_n     = HUNT;
          win_n       = '0;
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end
      CHECK: begin
        if (&is_digit) begin
          code_out_n   = bcd;
          code_valid_n = 1'b1;
        end else begin
          frame_err_n  = 1'b1;
        end
        state_n = HUNT;
        win_n   = '0;
      end
      default: begin
        state_n = HUNT;
        win_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      win        <= '0;
      payload    <= '0;
      bitcnt     <= '0;
      timer      <= '0;
      code_out   <= '0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      win        <= win_n;
      payload    <= payload_n;
      bitcnt     <= bitcnt_n;
      timer      <= timer_n;
      code_out   <= code_out_n;
      code_valid <= code_valid_n;
      frame_err  <= frame_err_n;
      busy       <= (state_n != HUNT);
    end
  end

endmodule

// File: tb/tb_code_rx.sv
// Directed bench for code_rx: a 4-byte receiver with a short timeout and a
// 1-byte receiver for back-to-back frames, checked against hand-computed values.
module tb_code_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bit_en4, code4, bit_en1, code1;
  logic [15:0] code_out4;
  logic [3:0]  code_out1;
  logic        code_valid4, frame_err4, busy4;
  logic        code_valid1, frame_err1, busy1;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int last_strobe = 0;
  int nv1 = 0, both4 = 0, both1 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  code_rx #(.N_BYTES(4), .SYNC(8'hA5), .TIMEOUT(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en4), .code(code4),
    .code_out(code_out4), .code_valid(code_valid4), .frame_err(frame_err4), .busy(busy4)
  );

  code_rx #(.N_BYTES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en1), .code(code1),
    .code_out(code_out1), .code_valid(code_valid1), .frame_err(frame_err1), .busy(busy1)
  );

  always @(negedge clk) begin
    if (code_valid1) nv1 <= nv1 + 1;
    if (code_valid4 && frame_err4) both4 <= both4 + 1;
    if (code_valid1 && frame_err1) both1 <= both1 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input int sel, input logic b, input logic en);
    if (sel == 4) begin code4 = b; bit_en4 = en; end
    else          begin code1 = b; bit_en1 = en; end
  endtask

  // Called at a negedge; strobes one bit after gap-1 idle cycles and returns
  // at the negedge right after the sampling edge.
  task automatic send_bit(input int sel, input logic b, input int gap);
    repeat (gap - 1) @(negedge clk);
    drive(sel, b, 1'b1);
    @(negedge clk);
    last_strobe = cyc;
    drive(sel, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input int gap);
    for (int i = 0; i < 8; i++) send_bit(sel, b[i], gap);
  endtask

  task automatic expect_done(input int sel, input string tag, input logic ok,
                             input logic [15:0] exp_code, input logic tail);
    logic v, e, b;
    logic [15:0] c;
    b = (sel == 4) ? busy4 : busy1;
    check({tag, "/busy_at_k"}, 32'(b), 32'd1);
    @(negedge clk);
    v = (sel == 4) ? code_valid4 : code_valid1;
    e = (sel == 4) ? frame_err4  : frame_err1;
    b = (sel == 4) ? busy4       : busy1;
    c = (sel == 4) ? code_out4   : {12'h000, code_out1};
    check({tag, "/valid"}, 32'(v), 32'(ok));
    check({tag, "/err"},   32'(e), 32'(!ok));
    check({tag, "/code"},  32'(c), 32'(exp_code));
    check({tag, "/busy"},  32'(b), 32'd0);
    if (tail) begin
      @(negedge clk);
      v = (sel == 4) ? code_valid4 : code_valid1;
      e = (sel == 4) ? frame_err4  : frame_err1;
      check({tag, "/pulse_end"}, 32'(v | e), 32'd0);
    end
  endtask

  task automatic frame4(input logic [31:0] bytes);
    send_byte(4, 8'hA5, 4);
    for (int i = 3; i >= 0; i--) send_byte(4, bytes[8*i +: 8], 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got_cyc;
    rst_n = 1'b0;
    bit_en4 = 1'b0; code4 = 1'b0; bit_en1 = 1'b0; code1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst/code_out4", 32'(code_out4), 32'h0);
    check("rst/valid4",    32'(code_valid4), 32'h0);
    check("rst/err4",      32'(frame_err4), 32'h0);
    check("rst/busy4",     32'(busy4), 32'h0);
    check("rst/code_out1", 32'(code_out1), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    frame4(32'h31323334);
    expect_done(4, "f1234", 1'b1, 16'h1234, 1'b1);

    frame4(32'h31324134);
    expect_done(4, "bad_digit", 1'b0, 16'h1234, 1'b1);

    send_byte(4, 8'h5A, 4);
    send_byte(4, 8'hFF, 4);
    frame4(32'h39383736);
    expect_done(4, "noise9876", 1'b1, 16'h9876, 1'b1);

    frame4(32'h39A53736);
    expect_done(4, "sync_in_data", 1'b0, 16'h9876, 1'b1);

    frame4(32'h39353736);
    expect_done(4, "f9576", 1'b1, 16'h9576, 1'b1);

    // Timeout: sync plus 10 payload bits, then silence.
    send_byte(4, 8'hA5, 4);
    send_byte(4, 8'h31, 4);
    send_bit(4, 1'b0, 4);
    send_bit(4, 1'b1, 4);
    got_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      if (frame_err4) begin got_cyc = cyc; break; end
      @(negedge clk);
    end
    check("timeout/latency", 32'(got_cyc - last_strobe), 32'd16);
    check("timeout/code",    32'(code_out4), 32'h9576);
    @(negedge clk);
    check("timeout/busy",    32'(busy4), 32'd0);
    frame4(32'h31303035);
    expect_done(4, "after_timeout", 1'b1, 16'h1005, 1'b1);

    // Reset in the middle of a frame.
    send_byte(4, 8'hA5, 4);
    send_byte(4, 8'h31, 4);
    send_byte(4, 8'h32, 4);
    for (int i = 0; i < 4; i++) send_bit(4, 1'b1, 4);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst/code_out", 32'(code_out4), 32'h0);
    check("midrst/valid",    32'(code_valid4), 32'h0);
    check("midrst/err",      32'(frame_err4), 32'h0);
    check("midrst/busy",     32'(busy4), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    frame4(32'h30303030);
    expect_done(4, "f0000", 1'b1, 16'h0000, 1'b1);

    // One-byte receiver, second frame strobed at edge k+2.
    send_byte(1, 8'hA5, 1);
    send_byte(1, 8'h37, 1);
    expect_done(1, "b2b_7", 1'b1, 16'h0007, 1'b0);
    send_byte(1, 8'hA5, 1);
    send_byte(1, 8'h33, 1);
    expect_done(1, "b2b_3", 1'b1, 16'h0003, 1'b1);
    repeat (2) @(negedge clk);
    check("b2b/pulse_count", 32'(nv1), 32'd2);
    check("exclusive4", 32'(both4), 32'd0);
    check("exclusive1", 32'(both1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
